// File: rtl/floo_link_cut.sv
// floo_link_cut: 2-entry full-throughput elastic buffer cutting every comb path on a mesh link.
// Also keeps saturating flit and backpressure counters for link-utilisation debug.
module floo_link_cut #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  input  logic                 clr_cnt_i,
  output logic [CntWidth-1:0]  flit_cnt_o,
  output logic [CntWidth-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    Empty = 2'd0,
    One   = 2'd1,
    Full  = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = '1;

  state_e               state_q;
  logic [DataWidth-1:0] slot_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [CntWidth-1:0]  flit_cnt_q;
  logic [CntWidth-1:0]  stall_cnt_q;

  logic push;
  logic pop;
  logic stall;

  // Handshake signals depend on state only, never on the opposite side.
  assign in_ready_o  = (state_q != Full) & rst_ni;
  assign out_valid_o = (state_q != Empty);
  assign out_data_o  = slot_q[rd_ptr_q];

  assign push  = in_valid_i & in_ready_o;
  assign pop   = out_valid_o & out_ready_i;
  assign stall = out_valid_o & ~out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= Empty;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case (state_q)
        Empty: begin
          if (push) state_q <= One;
        end
        One: begin
          if (push && !pop) begin
            state_q <= Full;
          end else if (pop && !push) begin
            state_q <= Empty;
          end
        end
        Full: begin
          if (pop) state_q <= One;
        end
        default: state_q <= Empty;
      endcase
    end
  end

  // Clear wins over any increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && flit_cnt_q != CntMax) begin
        flit_cnt_q <= flit_cnt_q + 1'b1;
      end
      if (stall && stall_cnt_q != CntMax) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign flit_cnt_o  = flit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_floo_link_cut.sv
// tb_floo_link_cut: directed and random stimulus with a queue scoreboard
// checked by a negedge monitor that also models the saturating counters.
module tb_floo_link_cut;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          clr;
  logic [CW-1:0] flit_cnt;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];
  int            m_flit;
  int            m_stall;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  floo_link_cut #(
    .DataWidth(DW),
    .CntWidth (CW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .clr_cnt_i  (clr),
    .flit_cnt_o (flit_cnt),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable from posedge+1, so the negedge view
  // is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_flit     = 0;
      m_stall    = 0;
      prev_stall = 1'b0;
    end else begin
      chk("flit_cnt_model", 32'(flit_cnt), 32'(m_flit));
      chk("stall_cnt_model", 32'(stall_cnt), 32'(m_stall));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(out_data), 32'hffff_ffff);
        end else begin
          chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (clr) begin
        m_flit  = 0;
        m_stall = 0;
      end else begin
        if (out_valid && out_ready && m_flit < CMAX) m_flit++;
        if (out_valid && !out_ready && m_stall < CMAX) m_stall++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr       = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);
    chk("rst_flit_cnt", 32'(flit_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Stream 1..8 at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      chk("stream_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_head", 32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_flits", 32'(flit_cnt), 32'd8);
    chk("stream_stalls", 32'(stall_cnt), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Backpressure fill with A, B; C waits upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_data = 16'h000C;
    tick();
    tick();
    chk("bp_ready_held", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_data), 32'h000A);
    chk("bp_stalls", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_flits", 32'(flit_cnt), 32'd3);
    chk("bp_stalls_end", 32'(stall_cnt), 32'd3);
    chk("bp_drained", 32'(out_valid), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Push 6 while popping 5 in ONE: no bubble.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    tick();
    in_data   = 16'h0006;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_head", 32'(out_data), 32'h0006);
    chk("pp_ready", 32'(in_ready), 32'd1);
    tick();
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Saturation then clear coinciding with a pop.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0030 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_flits", 32'(flit_cnt), 32'd15);
    in_valid = 1'b1;
    in_data  = 16'h0077;
    tick();
    in_valid = 1'b0;
    clr      = 1'b1;
    chk("clr_pop_valid", 32'(out_valid), 32'd1);
    tick();
    clr = 1'b0;
    chk("clr_over_pop", 32'(flit_cnt), 32'd0);

    // Reset while FULL: 0x11, 0x22 must never appear.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    in_valid = 1'b0;
    chk("mid_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready2", 32'(in_ready), 32'd0);
    chk("mid_rst_stalls", 32'(stall_cnt), 32'd0);
    chk("mid_rst_flits", 32'(flit_cnt), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_after_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_no_flits", 32'(flit_cnt), 32'd0);

    // Random traffic; an offered flit stays stable until accepted.
    for (int i = 0; i < 10000; i++) begin
      acc = in_valid && in_ready;
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floo_link_cut.md
Name: floo_link_cut

Overview:
Elastic retiming stage for one physical NoC mesh link channel (req, rsp or wide). It is inserted between a tile's router output and the neighbouring tile's router input in the top-level mesh wiring; the top places one instance per channel per link direction. Each instance is a 2-entry full-throughput valid/ready buffer, so no combinational path crosses the link. It also keeps saturating flit and backpressure counters for link-utilisation debug.

Parameters:
DataWidth, 64, width of the flit payload (set to the channel's flit width at instantiation)
CntWidth, 32, width of each performance counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
in_valid_i  in  1  upstream flit valid
in_ready_o  out  1  buffer can accept a flit
in_data_i  in  DataWidth  upstream flit payload
out_valid_o  out  1  downstream flit valid
out_ready_i  in  1  downstream accepts flit
out_data_o  out  DataWidth  downstream flit payload (head entry)
clr_cnt_i  in  1  synchronous clear of both counters
flit_cnt_o  out  CntWidth  number of output handshakes, saturating
stall_cnt_o  out  CntWidth  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- One clock; reset is synchronous and active-low (clk_i, rst_ni). All state updates on the rising edge of clk_i; rst_ni is sampled only at that edge.
- Reset values: state EMPTY, both data slots 0, write/read pointers 0, counters 0. After reset: out_valid_o=0, out_data_o=0, in_ready_o=1, flit_cnt_o=0, stall_cnt_o=0.
- While rst_ni=0, in_ready_o is forced to 0, so no flit is accepted in the reset cycle.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- States and transitions:
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE.
  - FULL: pop -> ONE. Push is impossible in FULL because ready is low.
- Outputs are decoded from state only:
  - in_ready_o = (state != FULL) & rst_ni.
  - out_valid_o = (state != EMPTY).
  - There is no combinational in_valid_i->out_valid_o or out_ready_i->in_ready_o path.
- Latency: a flit pushed at edge t is presented on out_valid_o/out_data_o in cycle t+1. Throughput is 1 flit/cycle with out_ready_i held at 1.
- Storage:
  - Two data slots form a FIFO with 1-bit write and read pointers. Each pointer toggles on its own handshake, so wrap-around is implicit.
  - out_data_o = slot[read pointer].
  - Strict FIFO order; no flit is dropped or duplicated.
- Output stability: once out_valid_o=1, out_valid_o and out_data_o remain unchanged until pop. out_data_o may show stale data while out_valid_o=0.
- Simultaneous push and pop in ONE: the head leaves and the new flit becomes head on the next cycle.
- Simultaneous push and pop in FULL: cannot occur.
- Counters:
  - flit_cnt increments on every pop.
  - stall_cnt increments every cycle with out_valid_o & !out_ready_i.
  - Both saturate at 2^CntWidth-1 and hold there.
  - clr_cnt_i=1 sets both to 0 at the edge and overrides any increment in the same cycle.
  - Counter outputs are registered.
- Reset mid-operation: buffered flits are discarded. State becomes EMPTY and counters become 0 at the reset edge. Upstream and downstream are reset by the same rst_ni.
- Upstream protocol obligation (not checked by the block): in_valid_i/in_data_i stay stable until push.

Test Plan:
- Reset then stream: out_ready_i=1, push 0x1..0x8 on consecutive cycles -> out_data_o shows 0x1..0x8 one cycle later each, in_ready_o stays 1, flit_cnt_o=8, stall_cnt_o=0.
- Backpressure fill: out_ready_i=0, offer 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready_o=0 from the cycle after the 2nd push, 0xC held upstream, stall_cnt_o increments each cycle. Then out_ready_i=1 -> outputs 0xA,0xB,0xC in order, flit_cnt_o=3.
- Push/pop in ONE: hold one flit 0x5, then push 0x6 while popping 0x5 -> state stays ONE, next head 0x6, no bubble.
- Counter saturation/clear: with CntWidth=4, 20 pops -> flit_cnt_o=15. Assert clr_cnt_i together with a pop -> flit_cnt_o=0 next cycle (no increment).
- Reset mid-operation: FULL with 0x11,0x22, assert rst_ni=0 for one edge -> out_valid_o=0, in_ready_o=0 during reset and 1 after, counters 0, neither 0x11 nor 0x22 ever emitted.
- Random valid/ready (10k cycles, 50% density on each side) against a scoreboard FIFO model -> order preserved, output stable under stall, flit_cnt_o equals scoreboard pop count.
